// File: rtl/miriscv_fetch_unit_if.sv
// Bundle of the fetch unit's two handshakes: the core-facing instruction
// delivery port (plus redirect) and the instruction-memory req/gnt/rvalid bus.
interface miriscv_fetch_unit_if;
  logic        fetch_valid_o;
  logic        fetch_ready_i;
  logic [31:0] fetch_instr_o;
  logic [31:0] fetch_pc_o;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;

  modport master (
    output fetch_valid_o, fetch_instr_o, fetch_pc_o, instr_req_o, instr_addr_o,
    input  fetch_ready_i, redirect_i, redirect_pc_i, instr_gnt_i,
           instr_rvalid_i, instr_rdata_i
  );

  modport slave (
    input  fetch_valid_o, fetch_instr_o, fetch_pc_o, instr_req_o, instr_addr_o,
    output fetch_ready_i, redirect_i, redirect_pc_i, instr_gnt_i,
           instr_rvalid_i, instr_rdata_i
  );
endinterface

// File: rtl/miriscv_fetch_unit.sv
// Instruction fetch unit: issues sequential word fetches, buffers in-order
// responses in a DEPTH-entry prefetch FIFO and hands {pc, instr} to the core.
// A redirect flushes the FIFO and discards responses still in flight.
module miriscv_fetch_unit #(
  parameter int          DEPTH     = 2,
  parameter logic [31:0] BOOT_ADDR = 32'h0
) (
  input logic                  clk_i,
  input logic                  arst_i,
  miriscv_fetch_unit_if.master bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = DEPTH[CW:0];

  logic [31:0]   fpc;
  logic [31:0]   resp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [CW-1:0] count;
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [63:0]   mem [DEPTH];

  logic [CW:0]   credit_used;
  logic [CW-1:0] outstanding_after;
  logic [31:0]   redirect_base;
  logic [63:0]   head;
  logic          req;
  logic          grant;
  logic          resp;
  logic          push;
  logic          pop;
  logic          empty;
  logic          full;
  logic          unused_pc_bits;

  // Credit counts both fetches in flight and entries already buffered, so a
  // response always has a free FIFO slot waiting for it.
  assign credit_used       = {1'b0, outstanding} + {1'b0, count};
  assign req               = !arst_i && !bus.redirect_i && (credit_used < DEPTH_W);
  assign grant             = req && bus.instr_gnt_i;
  // A response with nothing outstanding is spurious and ignored entirely.
  assign resp              = bus.instr_rvalid_i && (outstanding != '0);
  assign outstanding_after = resp ? outstanding - CW'(1) : outstanding;
  assign redirect_base     = {bus.redirect_pc_i[31:2], 2'b00};
  assign unused_pc_bits    = ^bus.redirect_pc_i[1:0];

  assign empty = (count == '0);
  assign full  = (count == DEPTH_W[CW-1:0]);
  assign push  = resp && (discard == '0) && !bus.redirect_i;
  assign pop   = !empty && bus.fetch_ready_i && !bus.redirect_i;
  assign head  = mem[rptr];

  // Everything presented to the outside world is forced low while in reset.
  assign bus.instr_req_o   = req;
  assign bus.instr_addr_o  = arst_i ? 32'h0 : fpc;
  assign bus.fetch_valid_o = !arst_i && !empty;
  assign bus.fetch_pc_o    = arst_i ? 32'h0 : head[63:32];
  assign bus.fetch_instr_o = arst_i ? 32'h0 : head[31:0];

  // Control state: fetch/response PCs, in-flight and discard counters, FIFO pointers.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      fpc         <= BOOT_ADDR;
      resp_pc     <= BOOT_ADDR;
      outstanding <= '0;
      discard     <= '0;
      count       <= '0;
      wptr        <= '0;
      rptr        <= '0;
    end else if (bus.redirect_i) begin
      // Every response still owed after this cycle belongs to the old stream.
      fpc         <= redirect_base;
      resp_pc     <= redirect_base;
      outstanding <= outstanding_after;
      discard     <= outstanding_after;
      count       <= '0;
      wptr        <= '0;
      rptr        <= '0;
    end else begin
      if (grant) fpc <= fpc + 32'd4;
      outstanding <= grant ? outstanding_after + CW'(1) : outstanding_after;
      if (resp && (discard != '0)) discard <= discard - CW'(1);
      if (push) begin
        resp_pc <= resp_pc + 32'd4;
        wptr    <= wptr + AW'(1);
      end
      if (pop) rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage holds data only, so it carries no reset.
  always_ff @(posedge clk_i) begin
    if (push) mem[wptr] <= {resp_pc, bus.instr_rdata_i};
  end

  // The credit rule must make a push into a full, non-draining FIFO impossible.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (arst_i) !(push && full && !pop));
endmodule

// File: tb/tb_miriscv_fetch_unit.sv
// Directed bench for miriscv_fetch_unit: a memory responder with configurable
// latency, a stimulus process and a scoreboard monitor checking delivered
// {pc, instr} against expected pcs queued by the stimulus.
module tb_miriscv_fetch_unit;
  logic clk  = 1'b0;
  logic arst = 1'b1;

  miriscv_fetch_unit_if bus ();

  miriscv_fetch_unit #(.DEPTH(2), .BOOT_ADDR(32'h0)) dut (
    .clk_i  (clk),
    .arst_i (arst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  int          tests_run    = 0;
  int          tests_failed = 0;
  int          cyc          = 0;
  int          lat          = 1;
  int          gnt_cnt      = 0;
  logic        gnt_en       = 1'b0;
  logic        ready_en     = 1'b0;
  logic        redir_pend   = 1'b0;
  logic [31:0] redir_pc     = 32'h0;
  mreq_t       mem_q[$];
  logic [31:0] exp_q[$];

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Memory model and input driver: drive at the falling edge, sample grants just before the rising edge.
  initial begin
    bus.fetch_ready_i  = 1'b0;
    bus.redirect_i     = 1'b0;
    bus.redirect_pc_i  = 32'h0;
    bus.instr_gnt_i    = 1'b0;
    bus.instr_rvalid_i = 1'b0;
    bus.instr_rdata_i  = 32'h0;
    forever begin
      @(negedge clk);
      cyc++;
      bus.instr_rvalid_i = 1'b0;
      bus.instr_rdata_i  = 32'h0;
      if (arst) begin
        mem_q.delete();
      end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
        bus.instr_rvalid_i = 1'b1;
        bus.instr_rdata_i  = mem_data(mem_q[0].addr);
        void'(mem_q.pop_front());
      end
      bus.instr_gnt_i   = gnt_en;
      bus.fetch_ready_i = ready_en;
      bus.redirect_i    = redir_pend;
      bus.redirect_pc_i = redir_pc;
      redir_pend        = 1'b0;
      #4;
      if (!arst && bus.instr_req_o && bus.instr_gnt_i) begin
        mem_q.push_back('{addr: bus.instr_addr_o, due: cyc + lat});
        gnt_cnt++;
      end
    end
  end

  // Scoreboard monitor: every accepted instruction is compared with the queue head.
  initial begin : monitor
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (!arst && bus.fetch_valid_o && bus.fetch_ready_i && !bus.redirect_i && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("deliver_pc", bus.fetch_pc_o, e);
        check("deliver_instr", bus.fetch_instr_o, mem_data(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #3;
    end
  endtask

  task automatic at_cycle(input int c);
    int guard;
    guard = 0;
    while (cyc < c && guard < 1000) begin
      tick(1);
      guard++;
    end
  endtask

  task automatic start(input logic g, input logic r, input int l, output int c0);
    arst       = 1'b1;
    gnt_en     = g;
    ready_en   = r;
    lat        = l;
    redir_pend = 1'b0;
    exp_q.delete();
    tick(2);
    gnt_cnt = 0;
    arst    = 1'b0;
    c0      = cyc;
    #1;
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      tick(1);
      n++;
    end
    check(name, 32'(exp_q.size()), 32'h0);
  endtask

  initial begin
    int c0;
    tick(2);
    check("reset_valid", 32'(bus.fetch_valid_o), 32'h0);
    check("reset_req", 32'(bus.instr_req_o), 32'h0);
    check("reset_addr", bus.instr_addr_o, 32'h0);

    // Streaming with single-cycle memory latency.
    start(1'b1, 1'b1, 1, c0);
    check("t1_first_req", 32'(bus.instr_req_o), 32'h1);
    check("t1_first_addr", bus.instr_addr_o, 32'h0);
    for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
    at_cycle(c0 + 1);
    check("t1_valid_c1", 32'(bus.fetch_valid_o), 32'h0);
    check("t1_addr_c1", bus.instr_addr_o, 32'h4);
    at_cycle(c0 + 2);
    check("t1_valid_c2", 32'(bus.fetch_valid_o), 32'h1);
    check("t1_pc_c2", bus.fetch_pc_o, 32'h0);
    drain("t1_drain", 40);

    // Core stalled: credit stops fetching; then a grant stall holds the address.
    start(1'b1, 1'b0, 1, c0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    exp_q.push_back(32'hC);
    at_cycle(c0 + 2);
    check("t2_req_stop", 32'(bus.instr_req_o), 32'h0);
    at_cycle(c0 + 4);
    check("t2_valid_full", 32'(bus.fetch_valid_o), 32'h1);
    check("t2_head_pc", bus.fetch_pc_o, 32'h0);
    check("t2_head_instr", bus.fetch_instr_o, mem_data(32'h0));
    check("t2_req_full", 32'(bus.instr_req_o), 32'h0);
    check("t2_grants", 32'(gnt_cnt), 32'h2);
    ready_en = 1'b1;
    gnt_en   = 1'b0;
    at_cycle(c0 + 5);
    check("t2_req_still_full", 32'(bus.instr_req_o), 32'h0);
    for (int k = 6; k <= 8; k++) begin
      at_cycle(c0 + k);
      check("t3_req_held", 32'(bus.instr_req_o), 32'h1);
      check("t3_addr_held", bus.instr_addr_o, 32'h8);
    end
    gnt_en = 1'b1;
    at_cycle(c0 + 10);
    check("t3_grants", 32'(gnt_cnt), 32'h3);
    check("t3_next_addr", bus.instr_addr_o, 32'hC);
    drain("t2_drain", 40);

    // Redirect with two fetches in flight.
    start(1'b1, 1'b1, 4, c0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    at_cycle(c0 + 2);
    check("t4_req_credit", 32'(bus.instr_req_o), 32'h0);
    check("t4_grants", 32'(gnt_cnt), 32'h2);
    at_cycle(c0 + 7);
    check("t4_pre_drain", 32'(exp_q.size()), 32'h0);
    check("t4_addr_c", bus.instr_addr_o, 32'hC);
    exp_q.delete();
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    redir_pc   = 32'h100;
    redir_pend = 1'b1;
    at_cycle(c0 + 8);
    check("t4_req_redirect", 32'(bus.instr_req_o), 32'h0);
    at_cycle(c0 + 9);
    check("t4_req_no_credit", 32'(bus.instr_req_o), 32'h0);
    at_cycle(c0 + 11);
    check("t4_req_new", 32'(bus.instr_req_o), 32'h1);
    check("t4_addr_new", bus.instr_addr_o, 32'h100);
    check("t4_valid_dropped", 32'(bus.fetch_valid_o), 32'h0);
    at_cycle(c0 + 16);
    check("t4_valid_new", 32'(bus.fetch_valid_o), 32'h1);
    check("t4_pc_new", bus.fetch_pc_o, 32'h100);
    drain("t4_drain", 40);

    // Redirect to an unaligned target coinciding with rvalid and a pop.
    start(1'b1, 1'b1, 1, c0);
    at_cycle(c0 + 1);
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    redir_pc   = 32'h103;
    redir_pend = 1'b1;
    at_cycle(c0 + 2);
    check("t5_req_redirect", 32'(bus.instr_req_o), 32'h0);
    check("t5_valid_at_redirect", 32'(bus.fetch_valid_o), 32'h1);
    at_cycle(c0 + 3);
    check("t5_flushed", 32'(bus.fetch_valid_o), 32'h0);
    check("t5_req_new", 32'(bus.instr_req_o), 32'h1);
    check("t5_addr_new", bus.instr_addr_o, 32'h100);
    drain("t5_drain", 40);

    // Asynchronous reset with a full FIFO, then with two fetches in flight.
    start(1'b1, 1'b0, 1, c0);
    at_cycle(c0 + 4);
    check("t6_full_valid", 32'(bus.fetch_valid_o), 32'h1);
    arst = 1'b1;
    #1;
    check("t6_valid_drop", 32'(bus.fetch_valid_o), 32'h0);
    check("t6_req_drop", 32'(bus.instr_req_o), 32'h0);
    start(1'b1, 1'b1, 4, c0);
    at_cycle(c0 + 2);
    check("t6_req_outstanding", 32'(bus.instr_req_o), 32'h0);
    arst = 1'b1;
    #1;
    check("t6_req_drop2", 32'(bus.instr_req_o), 32'h0);
    check("t6_addr_reset", bus.instr_addr_o, 32'h0);
    start(1'b1, 1'b1, 1, c0);
    check("t6_boot_req", 32'(bus.instr_req_o), 32'h1);
    check("t6_boot_addr", bus.instr_addr_o, 32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    drain("t6_drain", 40);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
